// File: rtl/sram_1p_ctrl_pkg.sv
// Shared constants for the single-port SRAM controller: response FIFO sizing,
// read credit limit and grant encodings.
package sram_1p_ctrl_pkg;

    localparam int RSP_DEPTH    = 4;
    localparam int CREDIT_LIMIT = 3;
    localparam int CNT_W        = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W        = $clog2(RSP_DEPTH);

    localparam logic [0:0] GNT_WR = 1'b0;
    localparam logic [0:0] GNT_RD = 1'b1;

    // A read may issue only if every response it could produce still has a FIFO slot.
    function automatic logic credit_ok(input logic [CNT_W-1:0] count, input logic inflight);
        logic [CNT_W-1:0] occ;
        occ = count + CNT_W'(inflight);
        return occ <= CNT_W'(CREDIT_LIMIT);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO holding read data until the consumer takes it.
module sram_rsp_fifo
    import sram_1p_ctrl_pkg::*;
#(
    parameter int WWORD = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WWORD-1:0] push_data,
    input  logic             pop,
    output logic [WWORD-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WWORD-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CNT_W'(RSP_DEPTH));
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_1p_ctrl.sv
// Single-port SRAM controller: alternating write/read arbitration, credit-gated
// reads and an in-order response FIFO with range checking.
module sram_1p_ctrl
    import sram_1p_ctrl_pkg::*;
#(
    parameter int WWORD = 32,
    parameter int WADDR = 5,
    parameter int DEPTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WADDR-1:0] wr_addr,
    input  logic [WWORD-1:0] wr_data,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [WADDR-1:0] rd_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WWORD-1:0] rsp_data,
    output logic             err,
    output logic             sram_cen,
    output logic             sram_wen,
    output logic [WADDR-1:0] sram_a,
    output logic [WWORD-1:0] sram_d,
    input  logic [WWORD-1:0] sram_q
);

    localparam logic [WADDR:0] DEPTH_L = (WADDR + 1)'(DEPTH);

    logic [0:0]       last_gnt;
    logic             inflight;
    logic             inflight_oor;
    logic             err_q;
    logic [WADDR-1:0] a_q;
    logic [WWORD-1:0] d_q;

    logic             rd_elig;
    logic             wr_gnt;
    logic             rd_gnt;
    logic             wr_oor;
    logic             rd_oor;
    logic             wr_issue;
    logic             rd_issue;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [WWORD-1:0] push_data;

    assign wr_oor  = ({1'b0, wr_addr} >= DEPTH_L);
    assign rd_oor  = ({1'b0, rd_addr} >= DEPTH_L);
    assign rd_elig = rd_valid && credit_ok(fifo_count, inflight);

    // Contention goes to the port that lost last time; the two readies are
    // mutually exclusive whenever both requests are present.
    assign wr_ready = !rst && !(rd_elig && last_gnt == GNT_WR);
    assign rd_ready = !rst && rd_elig && !(wr_valid && last_gnt == GNT_RD);

    assign wr_gnt   = wr_valid && wr_ready;
    assign rd_gnt   = rd_valid && rd_ready;
    assign wr_issue = wr_gnt && !wr_oor;
    assign rd_issue = rd_gnt && !rd_oor;

    always_comb begin
        sram_cen = 1'b1;
        sram_wen = 1'b1;
        sram_a   = a_q;
        sram_d   = d_q;
        if (rst) begin
            sram_a = '0;
            sram_d = '0;
        end else if (wr_issue) begin
            sram_cen = 1'b0;
            sram_wen = 1'b0;
            sram_a   = wr_addr;
            sram_d   = wr_data;
        end else if (rd_issue) begin
            sram_cen = 1'b0;
            sram_a   = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt     <= GNT_RD;
            inflight     <= 1'b0;
            inflight_oor <= 1'b0;
            err_q        <= 1'b0;
            a_q          <= '0;
            d_q          <= '0;
        end else begin
            if (wr_gnt)      last_gnt <= GNT_WR;
            else if (rd_gnt) last_gnt <= GNT_RD;
            inflight     <= rd_gnt;
            inflight_oor <= rd_gnt && rd_oor;
            err_q        <= (wr_gnt && wr_oor) || (rd_gnt && rd_oor);
            a_q          <= sram_a;
            d_q          <= sram_d;
        end
    end

    // Out-of-range reads still occupy a response slot so responses track accepts 1:1.
    assign push_data = inflight_oor ? '0 : sram_q;

    sram_rsp_fifo #(.WWORD(WWORD)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_data),
        .pop       (rsp_valid && rsp_ready),
        .head      (rsp_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign rsp_valid = !rst && !fifo_empty;
    assign err       = !rst && err_q;

endmodule

// File: tb/tb_sram_1p_ctrl.sv
// Directed bench for sram_1p_ctrl with a behavioural read-latency-1 SRAM model.
module tb_sram_1p_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;
    logic [4:0]  wr_addr, rd_addr, sram_a;
    logic [31:0] wr_data, rsp_data, sram_d, sram_q;
    logic        rsp_valid, rsp_ready, err, sram_cen, sram_wen;
    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_1p_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .err(err),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_a] <= sram_d;
            else           sram_q <= mem[sram_a];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        int n;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        n = 0;
        smp();
        while (!wr_ready && n < 10) begin
            cyc();
            smp();
            n++;
        end
        if (n == 10) check("write_timeout", 32'(wr_ready), 32'd1);
        cyc();
        wr_valid = 1'b0;
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
        sram_q    = '0;
        rst       = 1'b1;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_data   = '0;
        rsp_ready = 1'b0;

        // Outputs forced while in reset
        cyc();
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = 5'd7;
        wr_data  = 32'h1234_5678;
        smp();
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cen", 32'(sram_cen), 32'd1);
        check("rst_wen", 32'(sram_wen), 32'd1);
        check("rst_a", 32'(sram_a), 32'd0);
        check("rst_d", sram_d, 32'd0);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        do_reset();

        // Write then read back, 2-cycle read latency
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hA5A5_0001;
        smp();
        check("b2b_wr_ready", 32'(wr_ready), 32'd1);
        check("b2b_wr_cen", 32'(sram_cen), 32'd0);
        check("b2b_wr_wen", 32'(sram_wen), 32'd0);
        check("b2b_wr_a", 32'(sram_a), 32'd3);
        check("b2b_wr_d", sram_d, 32'hA5A5_0001);
        cyc();
        wr_valid  = 1'b0;
        rd_valid  = 1'b1;
        rd_addr   = 5'd3;
        rsp_ready = 1'b1;
        smp();
        check("b2b_rd_ready", 32'(rd_ready), 32'd1);
        check("b2b_rd_cen", 32'(sram_cen), 32'd0);
        check("b2b_rd_wen", 32'(sram_wen), 32'd1);
        check("b2b_rd_a", 32'(sram_a), 32'd3);
        check("b2b_idle_d_held", sram_d, 32'hA5A5_0001);
        cyc();
        rd_valid = 1'b0;
        smp();
        check("b2b_rsp_early", 32'(rsp_valid), 32'd0);
        check("b2b_idle_cen", 32'(sram_cen), 32'd1);
        check("b2b_idle_a_held", 32'(sram_a), 32'd3);
        cyc();
        smp();
        check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rsp_data", rsp_data, 32'hA5A5_0001);
        cyc();
        smp();
        check("b2b_rsp_popped", 32'(rsp_valid), 32'd0);

        // Read followed by a write to the same address returns pre-write data
        rd_valid = 1'b1;
        rd_addr  = 5'd3;
        cyc();
        rd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'hBEEF_0003;
        cyc();
        wr_valid = 1'b0;
        smp();
        check("rf_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rf_rsp_data", rsp_data, 32'hA5A5_0001);
        cyc();

        // Arbitration W,R,W,R after reset
        do_reset();
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'h5555_0005;
        rd_valid = 1'b1;
        rd_addr  = 5'd6;
        for (int c = 0; c < 4; c++) begin
            smp();
            check("arb_wr_ready", 32'(wr_ready), (c % 2 == 0) ? 32'd1 : 32'd0);
            check("arb_rd_ready", 32'(rd_ready), (c % 2 == 1) ? 32'd1 : 32'd0);
            check("arb_wen", 32'(sram_wen), (c % 2 == 0) ? 32'd0 : 32'd1);
            check("arb_cen", 32'(sram_cen), 32'd0);
            cyc();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        smp();
        check("arb_drained", 32'(rsp_valid), 32'd0);

        // Backpressure: four credits, then stall, then in-order drain
        for (int i = 10; i < 14; i++) do_write(5'(i), 32'h0000_1000 + 32'(i));
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            rd_addr = 5'(10 + acc);
            smp();
            if (rd_ready) acc++;
            cyc();
        end
        check("bp_accepted", 32'(acc), 32'd4);
        smp();
        check("bp_rd_ready_low", 32'(rd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rd_valid  = 1'b0;
        cyc();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            check("bp_drain_valid", 32'(rsp_valid), 32'd1);
            check("bp_drain_data", rsp_data, 32'h0000_1000 + 32'(10 + i));
            cyc();
        end
        smp();
        check("bp_empty", 32'(rsp_valid), 32'd0);
        rd_valid = 1'b1;
        rd_addr  = 5'd10;
        #1;
        check("bp_resume", 32'(rd_ready), 32'd1);
        cyc();
        rd_valid = 1'b0;
        cyc();
        cyc();

        // Out-of-range read and write
        rd_valid = 1'b1;
        rd_addr  = 5'd30;
        smp();
        check("oor_rd_ready", 32'(rd_ready), 32'd1);
        check("oor_rd_cen", 32'(sram_cen), 32'd1);
        cyc();
        rd_valid = 1'b0;
        smp();
        check("oor_rd_err", 32'(err), 32'd1);
        check("oor_rd_cen2", 32'(sram_cen), 32'd1);
        cyc();
        smp();
        check("oor_rd_err_once", 32'(err), 32'd0);
        check("oor_rsp_valid", 32'(rsp_valid), 32'd1);
        check("oor_rsp_data", rsp_data, 32'd0);
        cyc();
        smp();
        check("oor_rsp_single", 32'(rsp_valid), 32'd0);
        wr_valid = 1'b1;
        wr_addr  = 5'd24;
        wr_data  = 32'hFFFF_FFFF;
        smp();
        check("oor_wr_ready", 32'(wr_ready), 32'd1);
        check("oor_wr_cen", 32'(sram_cen), 32'd1);
        check("oor_wr_wen", 32'(sram_wen), 32'd1);
        cyc();
        wr_valid = 1'b0;
        smp();
        check("oor_wr_err", 32'(err), 32'd1);
        cyc();
        smp();
        check("oor_wr_err_once", 32'(err), 32'd0);
        check("oor_wr_no_rsp", 32'(rsp_valid), 32'd0);

        // Reset the cycle after a read issue discards it
        rd_valid = 1'b1;
        rd_addr  = 5'd3;
        cyc();
        rd_valid = 1'b0;
        rst      = 1'b1;
        smp();
        check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        cyc();
        rst = 1'b0;
        smp();
        check("mid_rst_rsp2", 32'(rsp_valid), 32'd0);
        cyc();
        smp();
        check("mid_rst_rsp3", 32'(rsp_valid), 32'd0);
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'h5555_0005;
        rd_valid = 1'b1;
        rd_addr  = 5'd6;
        #1;
        check("mid_rst_wr_first", 32'(wr_ready), 32'd1);
        check("mid_rst_rd_wait", 32'(rd_ready), 32'd0);
        check("mid_rst_wen", 32'(sram_wen), 32'd0);
        cyc();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        cyc();
        cyc();
        cyc();

        // Throughput: 16 back-to-back reads
        for (int i = 0; i < 16; i++) do_write(5'(i), 32'h0000_2000 + 32'(i));
        rsp_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            rd_valid = (c < 16);
            rd_addr  = 5'(c % 16);
            smp();
            if (c < 16) check("tp_rd_ready", 32'(rd_ready), 32'd1);
            if (c >= 2 && c < 18) begin
                check("tp_rsp_valid", 32'(rsp_valid), 32'd1);
                check("tp_rsp_data", rsp_data, 32'h0000_2000 + 32'(c - 2));
            end
            if (c == 18) check("tp_done", 32'(rsp_valid), 32'd0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_1p_ctrl.md
SRAM_1P_CTRL -- requirements
Module: sram_1p_ctrl

Interface
REQ-001 SHALL have parameter WWORD, default 32, data word width.
REQ-002 SHALL have parameter WADDR, default 5, address width.
REQ-003 SHALL have parameter DEPTH, default 24, valid words; addresses >= DEPTH are out of range.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_addr  in  WADDR  write address.
- wr_data  in  WWORD  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted when rd_valid & rd_ready.
- rd_addr  in  WADDR  read address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  WWORD  read response data.
- err  out  1  one-cycle pulse on out-of-range access.
- sram_cen  out  1  SRAM enable, active low.
- sram_wen  out  1  SRAM write enable, active low.
- sram_a  out  WADDR  SRAM address.
- sram_d  out  WWORD  SRAM write data.
- sram_q  in  WWORD  SRAM read data, valid one cycle after a read enable.
REQ-005 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-006 SHALL drive the SRAM through a single-port, read-latency-1 memory interface; at most one access per cycle.
REQ-007 SHALL drive sram_cen, sram_wen, sram_a and sram_d combinationally in the accept cycle: write gives cen=0, wen=0, a=wr_addr, d=wr_data; read gives cen=0, wen=1, a=rd_addr; idle gives cen=1, wen=1, a and d held at their last value.
REQ-008 SHALL consider a read eligible only when rd_valid=1 and (rsp FIFO occupancy + reads in flight) <= 3.
REQ-009 SHALL arbitrate when a write and an eligible read coincide:
- the port not granted last wins;
- after reset the write wins.
REQ-010 SHALL grant an unopposed request immediately; wr_ready and rd_ready SHALL depend only on the valids, state and eligibility, never on rsp_ready.
REQ-011 SHALL hold a 4-entry response FIFO; sram_q is pushed in the cycle after a read issue.
REQ-012 SHALL present the FIFO head on rsp_data with rsp_valid=1 while the FIFO is non-empty; pop on rsp_valid & rsp_ready.
REQ-013 SHALL sustain one read per cycle with rsp_ready held high: 1-cycle issue-to-push, head visible the next cycle, so read latency is 2 cycles.
REQ-014 SHALL allow simultaneous push and pop with occupancy unchanged; the FIFO SHALL never overflow, guaranteed by REQ-008.
REQ-015 SHALL handle an out-of-range accepted write as follows: sram_cen stays 1, err pulses in the cycle after acceptance, and no state changes.
REQ-016 SHALL handle an out-of-range accepted read as follows: sram_cen stays 1, err pulses, and a response of data 0 is pushed in program order, so response count always equals accepted-read count.
REQ-017 SHALL return the pre-write data for a write that follows a read to the same address (read-first ordering by issue order).
REQ-018 SHALL keep responses strictly in read-acceptance order.

Reset
REQ-019 SHALL, while rst=1, force wr_ready=0, rd_ready=0, rsp_valid=0, err=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
REQ-020 SHALL, on reset, clear the FIFO pointers, occupancy, in-flight flag and last-grant flag (to read, so the write wins first); a read in flight at reset is discarded.
REQ-021 SHALL leave SRAM contents unaffected by reset.

Structure
REQ-022 SHALL place the response FIFO depth (4) and the credit limit (3) in the shared package; WWORD, WADDR and DEPTH remain module parameters.
REQ-023 SHALL implement the response FIFO as sub-module sram_rsp_fifo (synchronous, 4-entry, push/pop/count); arbitration and credit logic remain in sram_1p_ctrl.

Verification
REQ-024 SHALL verify back-to-back access: write 0xA5A5_0001 to address 3, then read address 3 with rsp_ready=1 -> rsp_valid 2 cycles after the read acceptance, rsp_data=0xA5A5_0001.
REQ-025 SHALL verify arbitration: wr_valid and rd_valid held together for 4 cycles after reset -> grants W,R,W,R, with sram_wen low in cycles 1 and 3 only.
REQ-026 SHALL verify backpressure: rsp_ready=0, rd_valid=1 continuously -> exactly 4 reads accepted, then rd_ready=0; raising rsp_ready drains 4 responses in order and reads resume.
REQ-027 SHALL verify out-of-range access: read address 30 with DEPTH=24 -> sram_cen stays 1, err pulses once, one response with data 0; write to address 24 -> no SRAM enable, err pulses.
REQ-028 SHALL verify reset mid-operation: assert rst the cycle after a read issue -> no response appears, rsp_valid=0, and the first post-reset grant with both ports valid goes to the write.
REQ-029 SHALL verify throughput: 16 reads with rsp_ready=1 -> 16 responses in 17 cycles after the first accept, addresses in order.
